icecream_trace: RTL and testbench

- Synthesizable, parametrised successor to the IceCream debug print macros.
- Watches NUM_CH value channels and records value changes (or every cycle) as time-stamped entries in an internal DEPTH-entry FIFO.
- Entries are drained through a valid/ready port.
- Sits beside the logic under debug: in simulation, or on silicon/FPGA feeding a debug readout path.

---
 rtl/icecream_trace.sv | 178 +++++++++++++++++
 tb/tb_icecream_trace.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/icecream_trace.sv
// icecream_trace: watches NUM_CH value channels and records value changes
// (mode=0) or every enabled cycle (mode=1) as time-stamped entries in a
// DEPTH-entry FIFO, drained through a valid/ready port.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en, mode, ch_mask   capture enable, 0=on change / 1=every cycle, per-channel enable
//   ch_data             channel i at bits [i*WIDTH +: WIDTH]
//   out_valid/out_ready FIFO head handshake; out_ch/out_data/out_ts = head entry
//   level               FIFO occupancy
//   drop_cnt            saturating count of overwritten (lost) events
//
// Optional: define ICECREAM_TRACE_DISPLAY_EN to print every push and every
// drop-count increment in simulation. The default build has no system tasks.

// Per-channel capture lane: change detector, hold register and pending flag.
module icecream_trace_ch #(
  parameter int WIDTH = 32,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mask,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  input  logic [TS_W-1:0]  ts,
  input  logic             push_clr,   // this lane is being pushed this edge
  output logic             ev,
  output logic             pending,
  output logic [WIDTH-1:0] hold_data,
  output logic [TS_W-1:0]  hold_ts
);
  logic [WIDTH-1:0] prev;

  assign ev = en & mask & (mode | (data != prev));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      pending   <= 1'b0;
      hold_data <= '0;
      hold_ts   <= '0;
    end else begin
      // prev tracks unconditionally so re-enabling never sees stale changes
      prev <= data;
      if (ev) begin
        hold_data <= data;
        hold_ts   <= ts;
        pending   <= 1'b1;   // new event wins over a same-edge push clear
      end else if (push_clr) begin
        pending   <= 1'b0;
      end
    end
  end
endmodule

module icecream_trace #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           out_ch,
  output logic [WIDTH-1:0]        out_data,
  output logic [TS_W-1:0]         out_ts,
  output logic [LW-1:0]           level,
  output logic [15:0]             drop_cnt
);
  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] data;
    logic [TS_W-1:0]  ts;
  } entry_t;

  logic [TS_W-1:0]              ts;
  logic [NUM_CH-1:0]            ev, pend, push_clr, drops;
  logic [NUM_CH-1:0][WIDTH-1:0] hold_data;
  logic [NUM_CH-1:0][TS_W-1:0]  hold_ts;
  logic [CW-1:0]                sel;
  logic                         push, pop;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [16:0]                  drop_sum;
  entry_t                       mem [DEPTH];
  entry_t                       head;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    icecream_trace_ch #(.WIDTH(WIDTH), .TS_W(TS_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mask      (ch_mask[i]),
      .mode      (mode),
      .data      (ch_data[i*WIDTH +: WIDTH]),
      .ts        (ts),
      .push_clr  (push_clr[i]),
      .ev        (ev[i]),
      .pending   (pend[i]),
      .hold_data (hold_data[i]),
      .hold_ts   (hold_ts[i])
    );
    assign push_clr[i] = push & (sel == CW'(i));
  end

  // lowest-index pending channel wins
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pend[i]) sel = CW'(i);
  end

  assign pop   = (level != '0) & out_ready;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push  = (|pend) & ((level != LW'(DEPTH)) | pop);
  // an event on a pending lane that is not leaving this edge loses the old entry
  assign drops = ev & pend & ~push_clr;

  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_CH; i++)
      drop_sum = drop_sum + {16'd0, drops[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      ts       <= ts + 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // storage needs no reset: level gates every read
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{ch: sel, data: hold_data[sel], ts: hold_ts[sel]};
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (level != '0);
  assign out_ch    = out_valid ? head.ch   : '0;
  assign out_data  = out_valid ? head.data : '0;
  assign out_ts    = out_valid ? head.ts   : '0;

`ifdef ICECREAM_TRACE_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push)
        $display("IC_SV:: @%0t CH%0d TS:%0d DATA(%0h)", $time, sel, hold_ts[sel], hold_data[sel]);
      for (int i = 0; i < NUM_CH; i++)
        if (drops[i] && drop_cnt != 16'hFFFF)
          $display("IC_SV:: @%0t CH%0d DROP", $time, i);
    end
  end
`endif

endmodule

// File: tb/tb_icecream_trace.sv
module tb_icecream_trace;
  localparam int NUM_CH = 4, WIDTH = 32, DEPTH = 16, TS_W = 32;

  logic                    clk = 1'b0;
  logic                    rst, en, mode, out_ready;
  logic [NUM_CH-1:0]       ch_mask;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic                    out_valid;
  logic [1:0]              out_ch;
  logic [WIDTH-1:0]        out_data;
  logic [TS_W-1:0]         out_ts;
  logic [4:0]              level;
  logic [15:0]             drop_cnt;

  icecream_trace #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ch_mask(ch_mask), .ch_data(ch_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .out_ts(out_ts), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: trace entries as a queue, per-channel pending slots.
  typedef struct { int ch; logic [31:0] data; logic [31:0] ts; } ent_t;
  ent_t        q[$];
  logic [31:0] mprev[NUM_CH], mhd[NUM_CH], mht[NUM_CH];
  bit          mpend[NUM_CH];
  logic [31:0] mts;
  int          mdrop;

  task automatic model_edge();
    int  win, lvl;
    bit  pop;
    logic [31:0] d;
    if (rst) begin
      q.delete();
      for (int i = 0; i < NUM_CH; i++) begin mprev[i] = 0; mhd[i] = 0; mht[i] = 0; mpend[i] = 0; end
      mts = 0; mdrop = 0;
      return;
    end
    lvl = q.size();
    pop = (lvl != 0) && out_ready;
    win = -1;
    for (int i = 0; i < NUM_CH; i++) if (mpend[i] && win < 0) win = i;
    if (pop) void'(q.pop_front());
    if (win >= 0 && (lvl < DEPTH || pop)) begin
      q.push_back('{win, mhd[win], mht[win]});
      mpend[win] = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      d = ch_data[i*WIDTH +: WIDTH];
      if (en && ch_mask[i] && (mode || d != mprev[i])) begin
        if (mpend[i] && mdrop < 65535) mdrop++;
        mhd[i] = d; mht[i] = mts; mpend[i] = 1;
      end
      mprev[i] = d;
    end
    mts = mts + 1;
  endtask

  task automatic step(input bit do_chk = 1'b1);
    model_edge();
    @(posedge clk);
    #1;
    if (do_chk) begin
      chk("level", level, q.size());
      chk("valid", out_valid, q.size() != 0);
      chk("drop", drop_cnt, mdrop);
      if (q.size() != 0) begin
        chk("ch", out_ch, q[0].ch);
        chk("data", out_data, q[0].data);
        chk("ts", out_ts, q[0].ts);
      end
    end
  endtask

  task automatic set_ch(input int i, input logic [31:0] v);
    ch_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; out_ready = 1'b1; ch_mask = '1; ch_data = '0;
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_drop", drop_cnt, 16'd0);

    // 1. single change sampled at ts=10
    repeat (10) step();
    set_ch(1, 32'hA5);
    step();
    chk("t1_early", out_valid, 1'b0);
    step();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_ch", out_ch, 2'd1);
    chk("t1_data", out_data, 32'hA5);
    chk("t1_ts", out_ts, 32'd10);
    step();
    chk("t1_single", out_valid, 1'b0);

    // 2. ch0 and ch2 change on the same edge (ts=20)
    while (mts != 20) step();
    set_ch(0, 32'h1); set_ch(2, 32'h2);
    step(); step();
    chk("t2_ch_a", out_ch, 2'd0);
    chk("t2_ts_a", out_ts, 32'd20);
    step();
    chk("t2_ch_b", out_ch, 2'd2);
    chk("t2_ts_b", out_ts, 32'd20);
    chk("t2_drop", drop_cnt, 16'd0);
    step();

    // 5. gating by en and by mask
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin set_ch(3, $urandom); set_ch(0, $urandom); step(); end
    chk("t5_en_gate", level, 5'd0);
    en = 1'b1; step(); step();
    chk("t5_reenable", out_valid, 1'b0);
    ch_mask = 4'b0111;
    for (int k = 0; k < 4; k++) begin set_ch(3, $urandom); step(); end
    chk("t5_mask_gate", level, 5'd0);
    ch_mask = '1; step();
    set_ch(3, 32'hBEEF); step(); step();
    chk("t5_captured", out_ch, 2'd3);
    chk("t5_cap_data", out_data, 32'hBEEF);
    step();

    // 4. backpressure: hold then drain in order (model checks every cycle)
    out_ready = 1'b0; mode = 1'b1; ch_mask = 4'b0001;
    for (int k = 0; k < 3; k++) begin set_ch(0, 32'h100 + k); step(); end
    ch_mask = '0; mode = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (6) step();
    chk("t4_drained", level, 5'd0);

    // 6. reset mid-operation
    ch_data = '0; do_reset();
    out_ready = 1'b0; mode = 1'b1; ch_mask = 4'b0001;
    repeat (6) step();
    chk("t6_pre_level", level, 5'd5);
    ch_data = '0; do_reset();
    chk("t6_level", level, 5'd0);
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_drop", drop_cnt, 16'd0);
    chk("t6_data", out_data, 32'd0);
    mode = 1'b0; ch_mask = '1; out_ready = 1'b1;
    repeat (3) step();
    set_ch(2, 32'h7); step(); step();
    chk("t6_ts", out_ts, 32'd3);
    chk("t6_ch", out_ch, 2'd2);
    step();

    // 3. fill, overflow, saturation
    ch_data = '0; do_reset();
    out_ready = 1'b0; mode = 1'b1; ch_mask = 4'b0001;
    repeat (17) step();
    chk("t3_full", level, 5'd16);
    step();
    chk("t3_drop1", drop_cnt, 16'd1);
    step();
    chk("t3_drop2", drop_cnt, 16'd2);
    ch_mask = '1;
    for (int k = 0; k < 20000 && mdrop < 65535; k++) step(1'b0);
    repeat (10) step(1'b0);
    step();
    chk("t3_sat", drop_cnt, 16'hFFFF);

    // random phase
    ch_data = '0; do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 9) != 0);
      mode      = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ch_mask   = 4'($urandom);
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 3) == 0) set_ch(i, ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3)));
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
